insn_fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the core's decoder.

---
 rtl/insn_fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_insn_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_fetch_unit.sv
// Instruction fetch unit: reads byte-wide program ROM, assembles 16-bit
// instructions (high byte at the even address, low byte at address+1), and
// queues them in a small FIFO that the decoder drains over valid/ready.
// A redirect flushes the FIFO and restarts fetch at a new PC. A ROM read
// still outstanding at that point is drained and its data dropped.
module insn_fetch_unit #(
  parameter int                ADDR_W   = 13,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [7:0]        rom_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [15:0]       ins,
  output logic [ADDR_W-1:0] ins_pc
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  LAST_C   = PTR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] EVEN_MSK = ~ADDR_W'(1);
  localparam logic [ADDR_W-1:0] START_PC = RESET_PC & EVEN_MSK;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH_HI,
    S_FETCH_LO,
    S_DRAIN
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_hi;
  logic [15:0]         r_mem_ins [DEPTH];
  logic [ADDR_W-1:0]   r_mem_pc  [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic                w_pop;
  logic                w_push;
  logic                w_hi_ld;
  logic                w_addr_ld;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [CNT_W-1:0]    w_cnt_after_push;
  logic                w_start_idle;
  logic                w_start_lo;

  // Circular pointer advance for a FIFO whose depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + PTR_W'(1);
  endfunction

  assign ins_valid = (r_count != '0);
  assign w_pop     = ins_valid & ins_ready;
  assign rom_rd    = (r_state != S_IDLE);
  assign rom_addr  = r_addr;
  assign ins       = ins_valid ? r_mem_ins[r_rd_ptr] : '0;
  assign ins_pc    = ins_valid ? r_mem_pc[r_rd_ptr]  : '0;

  // The instruction in flight holds a reserved slot. A new fetch starts only
  // when that instruction's push, plus any same-cycle pop, leaves space.
  assign w_cnt_after_push = r_count + CNT_W'(1) - CNT_W'(w_pop);
  assign w_start_idle     = !halt && (r_count < DEPTH_C);
  assign w_start_lo       = !halt && (w_cnt_after_push < DEPTH_C);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state decode. Redirect overrides everything else. A pending ROM
  // request must still run to its ack, so it goes through DRAIN.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_hi_ld     = 1'b0;
    w_addr_ld   = 1'b0;
    w_addr_nxt  = r_addr;
    if (redirect) begin
      if ((r_state != S_IDLE) && !rom_ack) w_state_nxt = S_DRAIN;
      else                                 w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_idle) begin
            w_state_nxt = S_FETCH_HI;
            w_addr_ld   = 1'b1;
            w_addr_nxt  = r_pc;
          end
        end
        S_FETCH_HI: begin
          if (rom_ack) begin
            w_hi_ld     = 1'b1;
            w_state_nxt = S_FETCH_LO;
            w_addr_ld   = 1'b1;
            w_addr_nxt  = r_pc + ADDR_W'(1);
          end
        end
        S_FETCH_LO: begin
          if (rom_ack) begin
            w_push = 1'b1;
            if (w_start_lo) begin
              w_state_nxt = S_FETCH_HI;
              w_addr_ld   = 1'b1;
              w_addr_nxt  = r_pc + ADDR_W'(2);
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if (rom_ack) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Program counter and ROM address. The address only moves when a new
  // request starts, so it stays put through DRAIN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc   <= START_PC;
      r_addr <= RESET_PC;
    end else begin
      if (redirect)    r_pc <= redirect_pc & EVEN_MSK;
      else if (w_push) r_pc <= r_pc + ADDR_W'(2);
      if (w_addr_ld)   r_addr <= w_addr_nxt;
    end
  end

  // High-byte latch, cleared on redirect so no stale byte can survive.
  always_ff @(posedge clk) begin
    if (redirect)     r_hi <= '0;
    else if (w_hi_ld) r_hi <= rom_data;
  end

  // FIFO occupancy and pointers. Redirect empties the queue outright.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // FIFO storage: the assembled instruction tagged with its high-byte address.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_ins[r_wr_ptr] <= {r_hi, rom_data};
      r_mem_pc[r_wr_ptr]  <= r_pc;
    end
  end

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Bench for insn_fetch_unit: a byte ROM with programmable latency and an
// in-order instruction-stream model, plus directed literal checks.
module tb_insn_fetch_unit;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rom_rd;
  logic [AW-1:0] rom_addr;
  logic          rom_ack = 1'b0;
  logic [7:0]    rom_data = 8'h00;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          halt = 1'b0;
  logic          ins_valid;
  logic          ins_ready = 1'b0;
  logic [15:0]   ins;
  logic [AW-1:0] ins_pc;

  logic [7:0]    mem [0:8191];
  int            total = 0;
  int            bad = 0;
  int            lat = 0;

  logic          p_vld, p_rdy, p_redir, p_rd, p_ack;
  logic [15:0]   p_ins;
  logic [AW-1:0] p_pc, p_addr, exp_pc, a_lo;
  logic          found;

  insn_fetch_unit #(.ADDR_W(AW), .DEPTH(2), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .rom_rd(rom_rd), .rom_addr(rom_addr),
    .rom_ack(rom_ack), .rom_data(rom_data), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .ins(ins), .ins_pc(ins_pc)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rom_rd"},    32'(rom_rd),    32'd0);
    chk({tag, "_rom_addr"},  32'(rom_addr),  32'd0);
    chk({tag, "_ins_valid"}, 32'(ins_valid), 32'd0);
    chk({tag, "_ins"},       32'(ins),       32'd0);
    chk({tag, "_ins_pc"},    32'(ins_pc),    32'd0);
  endtask

  // ROM: answers each request after 'lat' wait cycles; lat=0 acks in the
  // same cycle the request is seen.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (rom_rd) begin
        if (wcnt >= lat) begin
          rom_ack  = 1'b1;
          rom_data = mem[rom_addr];
          wcnt     = 0;
        end else begin
          rom_ack = 1'b0;
          wcnt++;
        end
      end else begin
        rom_ack = 1'b0;
        wcnt    = 0;
      end
    end
  end

  // Stream model: the head must always be the next instruction in program
  // order from the last redirect/reset target, read straight from ROM.
  initial begin
    logic [AW-1:0] a1;
    p_vld = 0; p_rdy = 0; p_redir = 0; p_rd = 0; p_ack = 0;
    p_ins = '0; p_pc = '0; p_addr = '0; exp_pc = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        exp_pc = '0;
        p_vld = 0; p_rdy = 0; p_redir = 0; p_rd = 0; p_ack = 0;
      end else begin
        if (p_redir) chk("flush_after_redirect", 32'(ins_valid), 32'd0);
        if (p_rd && !p_ack) begin
          chk("rd_held", 32'(rom_rd), 32'd1);
          chk("addr_held", 32'(rom_addr), 32'(p_addr));
        end
        if (p_vld && !p_rdy && !p_redir) begin
          chk("head_vld_held", 32'(ins_valid), 32'd1);
          chk("head_ins_held", 32'(ins), 32'(p_ins));
          chk("head_pc_held", 32'(ins_pc), 32'(p_pc));
        end
        if (ins_valid) begin
          a1 = exp_pc + 13'd1;
          chk("model_ins", 32'(ins), 32'({mem[exp_pc], mem[a1]}));
          chk("model_pc", 32'(ins_pc), 32'(exp_pc));
          if (ins_ready) exp_pc = exp_pc + 13'd2;
        end
        if (redirect) exp_pc = redirect_pc & ~13'd1;
        p_vld = ins_valid; p_rdy = ins_ready; p_redir = redirect;
        p_rd = rom_rd; p_ack = rom_ack; p_addr = rom_addr;
        p_ins = ins; p_pc = ins_pc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[0] = 8'hA1; mem[1] = 8'h05; mem[2] = 8'hB2; mem[3] = 8'h16;
    mem[4] = 8'hC3; mem[5] = 8'h27; mem[6] = 8'hD4; mem[7] = 8'h38;
    mem[8] = 8'hE5; mem[9] = 8'h49;
    mem[13'h0100] = 8'h5E; mem[13'h0101] = 8'h6F;
    mem[13'h1FFE] = 8'h7A; mem[13'h1FFF] = 8'h8B;

    // 1: reset and first fetch with a zero-wait ROM
    #1 rst = 1'b0;
    #1 chk_reset_vals("rst0");
    @(posedge clk); @(posedge clk);
    tick(); rst = 1'b1;
    tick();
    chk("t1_rd_hi", 32'(rom_rd), 32'd1);
    chk("t1_addr_hi", 32'(rom_addr), 32'd0);
    tick();
    chk("t1_addr_lo", 32'(rom_addr), 32'd1);
    chk("t1_not_yet_valid", 32'(ins_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(ins_valid), 32'd1);
    chk("t1_ins", 32'(ins), 32'h0000A105);
    chk("t1_ins_pc", 32'(ins_pc), 32'd0);
    chk("t1_next_addr", 32'(rom_addr), 32'd2);

    // 2: backpressure fills both slots, then one pop allows one fetch
    tick();
    chk("t2_addr3", 32'(rom_addr), 32'd3);
    tick();
    chk("t2_stop_rd", 32'(rom_rd), 32'd0);
    tick(); tick();
    chk("t2_still_stopped", 32'(rom_rd), 32'd0);
    chk("t2_head_ins", 32'(ins), 32'h0000A105);
    ins_ready = 1'b1;
    tick(); ins_ready = 1'b0;
    chk("t2_pop_head", 32'(ins), 32'h0000B216);
    chk("t2_pop_pc", 32'(ins_pc), 32'd2);
    chk("t2_no_rd_same_cycle", 32'(rom_rd), 32'd0);
    tick();
    chk("t2_refetch_rd", 32'(rom_rd), 32'd1);
    chk("t2_refetch_hi", 32'(rom_addr), 32'd4);
    tick();
    chk("t2_refetch_lo", 32'(rom_addr), 32'd5);
    tick();
    chk("t2_full_again", 32'(rom_rd), 32'd0);

    // 5: pop coinciding with the low-byte ack keeps the occupancy steady
    ins_ready = 1'b1;
    tick(); ins_ready = 1'b0;
    chk("t5_head", 32'(ins), 32'h0000C327);
    tick();
    chk("t5_hi_addr", 32'(rom_addr), 32'd6);
    tick();
    chk("t5_lo_addr", 32'(rom_addr), 32'd7);
    ins_ready = 1'b1;
    tick(); ins_ready = 1'b0;
    chk("t5_vld", 32'(ins_valid), 32'd1);
    chk("t5_ins", 32'(ins), 32'h0000D438);
    chk("t5_ins_pc", 32'(ins_pc), 32'd6);
    chk("t5_continues", 32'(rom_addr), 32'd8);

    // 6: halt during FETCH_HI lets that instruction finish, then stops
    halt = 1'b1; ins_ready = 1'b1;
    tick(); ins_ready = 1'b0;
    chk("t6_lo_completes", 32'(rom_addr), 32'd9);
    chk("t6_lo_rd", 32'(rom_rd), 32'd1);
    tick();
    chk("t6_halted", 32'(rom_rd), 32'd0);
    chk("t6_ins", 32'(ins), 32'h0000E549);
    chk("t6_ins_pc", 32'(ins_pc), 32'd8);
    tick();
    chk("t6_still_halted", 32'(rom_rd), 32'd0);
    halt = 1'b0;
    tick();
    chk("t6_resume_rd", 32'(rom_rd), 32'd1);
    chk("t6_resume_addr", 32'(rom_addr), 32'd10);

    // 3: redirect during FETCH_LO against a slow ROM
    ins_ready = 1'b1; halt = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    lat = 3; halt = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (rom_rd && rom_addr[0]) found = 1'b1;
    end
    chk("t3_lo_seen", 32'(found), 32'd1);
    a_lo = rom_addr;
    redirect = 1'b1; redirect_pc = 13'h0101;
    tick(); redirect = 1'b0;
    chk("t3_flushed", 32'(ins_valid), 32'd0);
    chk("t3_drain_rd", 32'(rom_rd), 32'd1);
    chk("t3_drain_addr", 32'(rom_addr), 32'(a_lo));
    tick();
    chk("t3_drain_addr2", 32'(rom_addr), 32'(a_lo));
    tick();
    chk("t3_drain_addr3", 32'(rom_addr), 32'(a_lo));
    tick();
    chk("t3_idle_rd", 32'(rom_rd), 32'd0);
    chk("t3_no_push", 32'(ins_valid), 32'd0);
    tick();
    chk("t3_new_rd", 32'(rom_rd), 32'd1);
    chk("t3_new_addr", 32'(rom_addr), 32'h0100);

    // 4: wrap from the top of the address space
    lat = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (ins_valid) found = 1'b1;
    end
    chk("t4_target_seen", 32'(found), 32'd1);
    chk("t4_target_ins", 32'(ins), 32'h00005E6F);
    chk("t4_target_pc", 32'(ins_pc), 32'h0100);
    ins_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 13'h1FFE;
    tick(); redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (rom_rd && rom_addr == 13'h1FFE) found = 1'b1;
      else tick();
    end
    chk("t4_hi_seen", 32'(found), 32'd1);
    tick();
    chk("t4_lo_addr", 32'(rom_addr), 32'h1FFF);
    tick();
    chk("t4_vld", 32'(ins_valid), 32'd1);
    chk("t4_ins", 32'(ins), 32'h00007A8B);
    chk("t4_ins_pc", 32'(ins_pc), 32'h1FFE);
    chk("t4_wrap_addr", 32'(rom_addr), 32'd0);

    // 7: asynchronous reset while draining
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (rom_rd && !rom_ack) found = 1'b1;
    end
    chk("t7_pending_seen", 32'(found), 32'd1);
    redirect = 1'b1; redirect_pc = 13'h0040;
    tick(); redirect = 1'b0;
    chk("t7_drain_rd", 32'(rom_rd), 32'd1);
    chk("t7_drain_addr", 32'(rom_addr), 32'd1);
    chk("t7_drain_flushed", 32'(ins_valid), 32'd0);
    rst = 1'b0;
    #1 chk_reset_vals("t7_async");
    tick(); tick();
    lat = 0; rst = 1'b1;
    tick();
    chk("t7_restart_rd", 32'(rom_rd), 32'd1);
    chk("t7_restart_addr", 32'(rom_addr), 32'd0);
    tick();
    chk("t7_restart_lo", 32'(rom_addr), 32'd1);
    tick();
    chk("t7_restart_vld", 32'(ins_valid), 32'd1);
    chk("t7_restart_ins", 32'(ins), 32'h0000A105);
    chk("t7_restart_pc", 32'(ins_pc), 32'd0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
